// File: rtl/seq_mul32.sv
// ---------------------------------------------------------------------------
// seq_mul32 -- 32x32 unsigned shift-and-add multiplier, one bit per clock.
//
// The 32-bit adder sits outside this block. It must be combinational, and
// this block uses its sum and carry-out in the same cycle.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; mcand, mplier are captured on
//                         the edge where both are high (only in IDLE)
//   mcand, mplier         32-bit unsigned operands
//   out_valid / out_ready product handshake; product is held while waiting
//   product               64-bit result {P_hi, Q}
//   busy                  high while iterating (RUN)
//   add_a, add_b, add_cin operands to the external adder (add_cin always 0)
//   add_sum, add_cout     result from the external adder
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer keeps valid and data stable until that edge.
//
// Build option
//   SEQ_MUL_EARLY_TERM_EN  When defined, RUN ends as soon as the unconsumed
//                          multiplier bits are all zero. The partial
//                          {P_hi, Q} is then right-aligned, so the product
//                          matches the 32-iteration result. When it is not
//                          defined, every operation takes exactly 32
//                          iterations.
// ---------------------------------------------------------------------------
module seq_mul32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        busy,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] m;
    logic [31:0] q;
    logic [31:0] p_hi;
    logic [5:0]  cnt;
    logic [5:0]  cnt_n;
    logic [63:0] nxt;

    // Q shifts right by one bit each iteration. The low adder sum bit enters
    // at Q's top, and the adder carry becomes the top bit of P_hi.
    assign nxt   = {add_cout, add_sum, q[31:1]};
    assign cnt_n = cnt + 6'd1;

`ifdef SEQ_MUL_EARLY_TERM_EN
    logic        rem_zero;
    logic [63:0] nxt_aligned;
    // After this iteration, the multiplier bits not yet consumed are
    // q[31:cnt+1]. Seen through q[31:1], they are its low (31-cnt) bits.
    // When cnt == 31 the mask is empty, so rem_zero is always set then.
    assign rem_zero    = (({1'b0, q[31:1]} & (32'hFFFF_FFFF >> cnt_n)) == 32'd0);
    // Finishing early leaves the product (32-cnt_n) bits too far left.
    // When cnt_n == 32 the shift is zero.
    assign nxt_aligned = nxt >> (6'd32 - cnt_n);
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign product   = {p_hi, q};
    assign add_a     = p_hi;
    assign add_b     = q[0] ? m : 32'd0;
    assign add_cin   = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (in_valid) state_n = RUN;
`ifdef SEQ_MUL_EARLY_TERM_EN
            RUN:  if (rem_zero) state_n = DONE;
`else
            RUN:  if (cnt == 6'd31) state_n = DONE;
`endif
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m    <= 32'd0;
            q    <= 32'd0;
            p_hi <= 32'd0;
            cnt  <= 6'd0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                m    <= mcand;
                q    <= mplier;
                p_hi <= 32'd0;
                cnt  <= 6'd0;
            end
        end else if (state == RUN) begin
`ifdef SEQ_MUL_EARLY_TERM_EN
            if (rem_zero) {p_hi, q} <= nxt_aligned;
            else          {p_hi, q} <= nxt;
`else
            {p_hi, q} <= nxt;
`endif
            cnt <= cnt_n;
        end
    end

endmodule

// File: doc/seq_mul32.md
SEQ_MUL32 -- requirements
Module: seq_mul32

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, operand pair valid.
REQ-004 SHALL have port in_ready, output, 1, block can accept operands.
REQ-005 SHALL have port mcand, input, 32, unsigned multiplicand.
REQ-006 SHALL have port mplier, input, 32, unsigned multiplier.
REQ-007 SHALL have port out_valid, output, 1, product valid.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts product.
REQ-009 SHALL have port product, output, 64, unsigned mcand*mplier.
REQ-010 SHALL have port busy, output, 1, high in RUN.
REQ-011 SHALL have port add_a, output, 32, A operand to the external 32-bit carry-lookahead adder.
REQ-012 SHALL have port add_b, output, 32, B operand to the external adder.
REQ-013 SHALL have port add_cin, output, 1, adder carry-in, tied 0.
REQ-014 SHALL have port add_sum, input, 32, adder sum, combinational same cycle.
REQ-015 SHALL have port add_cout, input, 1, adder carry-out, combinational same cycle.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL assert in_ready only in IDLE; accept when in_valid&&in_ready: load M=mcand, Q=mplier, P_hi=0, cnt=0, go RUN.
REQ-018 SHALL drive add_a=P_hi, add_b=Q[0] ? M : 0, add_cin=0 in all states.
REQ-019 SHALL, each RUN edge, load {P_hi,Q} <= {add_cout,add_sum,Q[31:1]} and increment 6-bit cnt.
REQ-020 SHALL go RUN->DONE on the edge where cnt==31 (32 iterations); DONE entered exactly 32 edges after the accept edge.
REQ-021 SHALL, in DONE, hold out_valid=1 and product={P_hi,Q} stable until out_valid&&out_ready, then go IDLE on that edge.
REQ-022 SHALL ignore in_valid, mcand, mplier outside IDLE; no new accept in the DONE->IDLE edge.
REQ-023 SHALL never overflow: 32x32 unsigned product always fits 64 bits; add_cout captured as P_hi bit shifted in.
REQ-024 SHALL deassert out_valid in IDLE and RUN; product value outside DONE is don't-care but deterministic.
REQ-025 SHALL assert busy exactly while state==RUN.

Reset
REQ-026 SHALL, on rst_n low (any time, incl. mid-RUN or DONE), immediately force state IDLE, cnt=0, M=Q=P_hi=0, out_valid=0, busy=0, in_ready=1 after release.
REQ-027 SHALL discard any in-flight operation on reset; no product emitted for it.

Configuration
REQ-028 SHALL support macro SEQ_MUL_EARLY_TERM_EN.
REQ-029 SHALL, with SEQ_MUL_EARLY_TERM_EN defined, in RUN go to DONE when Q's remaining unconsumed multiplier bits are all zero, loading product={P_hi,Q} logically right-shifted by (32-cnt) so the result equals full 32-iteration result; mplier==0 reaches DONE one edge after accept.
REQ-030 SHALL, without SEQ_MUL_EARLY_TERM_EN, always run 32 iterations (fixed latency per REQ-020).

Verification
REQ-031 SHALL verify mcand=3, mplier=5 accepted at edge E0 -> out_valid at E32, product=64'h0000_0000_0000_000F (macro off).
REQ-032 SHALL verify mcand=mplier=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001, add_cout=1 captured correctly.
REQ-033 SHALL verify out_ready held 0 for 10 cycles in DONE -> product and out_valid stable, in_ready=0, new in_valid ignored.
REQ-034 SHALL verify rst_n pulsed low at iteration 16 -> out_valid=0 immediately, in_ready=1 after release, next op 7*9 gives 63.
REQ-035 SHALL verify with SEQ_MUL_EARLY_TERM_EN: mcand=7, mplier=1 -> DONE 1 edge after accept, product=7; mplier=0 -> product=0.
REQ-036 SHALL verify 1000 random operand pairs with random out_ready -> every product equals reference mcand*mplier.
